// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction-side OBI responder.
// One entry per granted fetch: the data captured at grant and a countdown until it may be returned.
package cv32e40p_pkg;

    localparam int OBI_CNT_W = 8;

    typedef struct packed {
        logic [31:0]          rdata;
        logic                 err;
        logic [OBI_CNT_W-1:0] cnt;
    } obi_resp_entry_t;

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response queue.
// Each live entry counts down to zero; the head may leave only once its count has expired.
module cv32e40p_obi_resp_fifo
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  obi_resp_entry_t push_entry,
    input  logic            pop,
    output logic            head_ready,
    output obi_resp_entry_t head,
    output logic [CW-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    obi_resp_entry_t entries [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head       = entries[rd_ptr];
    assign head_ready = vld[rd_ptr] && (head.cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // The freshly pushed slot is never live, so its write below wins over the decrement.
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && entries[i].cnt != '0)
                    entries[i].cnt <= entries[i].cnt - 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= push_entry;
                vld[wr_ptr]     <= 1'b1;
                wr_ptr          <= nxt(wr_ptr);
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= nxt(rd_ptr);
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && vld[wr_ptr]));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !vld[rd_ptr]));

endmodule

// File: rtl/cv32e40p_instr_obi_responder.sv
// Memory end of the instruction fetch OBI port: backdoor-loadable word memory,
// grant throttled by outstanding count, in-order responses after a fixed latency.
module cv32e40p_instr_obi_responder
    import cv32e40p_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               instr_req_i,
    input  logic [31:0]                        instr_addr_i,
    output logic                               instr_gnt_o,
    output logic                               instr_rvalid_o,
    output logic [31:0]                        instr_rdata_o,
    output logic                               instr_err_o,
    input  logic                               gnt_stall_i,
    input  logic                               rvalid_stall_i,
    input  logic                               load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]       load_addr_i,
    input  logic [31:0]                        load_wdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]     mem [MEM_WORDS];
    logic [31:0]     off;
    logic            addr_err;
    logic            head_ready;
    obi_resp_entry_t push_entry;
    obi_resp_entry_t head;

    // Addresses below BASE_ADDR wrap to a huge offset and fall into the range error.
    assign off      = instr_addr_i - BASE_ADDR;
    assign addr_err = (instr_addr_i[1:0] != 2'b00) ||
                      ({1'b0, off} >= (33'(MEM_WORDS) * 33'd4));

    // Count excludes a same-cycle pop on purpose: a slot freed now is usable next cycle.
    assign instr_gnt_o = rst_n && instr_req_i && !gnt_stall_i &&
                         (outstanding_o < CW'(MAX_OUTSTANDING));

    always_comb begin
        push_entry       = '0;
        push_entry.err   = addr_err;
        push_entry.rdata = addr_err ? 32'h0 : mem[off[AW+1:2]];
        push_entry.cnt   = OBI_CNT_W'(RESP_LATENCY - 1);
    end

    // Read above sees the pre-edge contents, so a same-cycle backdoor write returns old data.
    always_ff @(posedge clk) begin
        if (load_we_i)
            mem[load_addr_i] <= load_wdata_i;
    end

    cv32e40p_obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (instr_gnt_o),
        .push_entry (push_entry),
        .pop        (instr_rvalid_o),
        .head_ready (head_ready),
        .head       (head),
        .count      (outstanding_o)
    );

    assign instr_rvalid_o = rst_n && head_ready && !rvalid_stall_i;
    assign instr_rdata_o  = instr_rvalid_o ? head.rdata : 32'h0;
    assign instr_err_o    = instr_rvalid_o && head.err;

endmodule
